// File: rtl/store_pkg.sv
// Shared types and constants for the store aligner: size encodings, byte-enable
// patterns, buffer depth and the packing helper used ahead of the buffer.
package store_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_ent_t;

    // Low address bits that a size cannot honour are simply ignored here.
    function automatic store_ent_t pack_store(input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input size_e       size);
        store_ent_t e;
        e.addr = {addr[31:2], 2'b00};
        case (size)
            SIZE_B: begin
                e.wdata = {4{data[7:0]}};
                e.be    = BE_BYTE << addr[1:0];
            end
            SIZE_H: begin
                e.wdata = {2{data[15:0]}};
                e.be    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: begin
                e.wdata = data;
                e.be    = BE_WORD;
            end
        endcase
        return e;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr, input size_e size);
        return ((size == SIZE_H) && addr[0]) || ((size == SIZE_W) && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic in-order buffer, registered head output.
// Latency: a push is visible on pop_dat the following cycle.
// Backpressure: push_rdy drops when full; no same-cycle bypass when a pop frees a slot.
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/store_aligner.sv
// Packs byte/half/word stores into lane-replicated word writes through a 2-entry buffer.
// Latency: 1 cycle from accept to mem_valid; drops (reserved size, or misaligned when
// STORE_ALIGNER_MISALIGN_EXC_EN is defined) pulse exc_valid 1 cycle later. Backpressure: req_ready low when full.
module store_aligner
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        exc_valid,
    output logic [31:0] exc_badvaddr
);
    store_ent_t in_ent;
    store_ent_t head_ent;
    logic [$bits(store_ent_t)-1:0] head_dat;
    logic drop, accept, push_rdy;

    always_comb begin
        in_ent = pack_store(req_addr, req_data, size_e'(req_size));
        drop   = (size_e'(req_size) == SIZE_RSV);
`ifdef STORE_ALIGNER_MISALIGN_EXC_EN
        drop   = drop || misaligned(req_addr, size_e'(req_size));
`endif
    end

    assign req_ready = push_rdy && !reset;
    assign accept    = req_valid && req_ready;

    store_fifo #(
        .WIDTH ($bits(store_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (accept && !drop),
        .push_rdy (push_rdy),
        .push_dat (in_ent),
        .pop_vld  (mem_valid),
        .pop_rdy  (mem_ready),
        .pop_dat  (head_dat)
    );

    assign head_ent  = store_ent_t'(head_dat);
    assign mem_addr  = head_ent.addr;
    assign mem_wdata = head_ent.wdata;
    assign mem_be    = head_ent.be;

    // Dropped requests still complete the handshake; only the exception records them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_valid    <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            exc_valid <= accept && drop;
            if (accept && drop)
                exc_badvaddr <= req_addr;
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Randomised and directed bench for store_aligner against a queue-based reference model.
module tb_store_aligner;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_valid;
    logic [31:0] exc_badvaddr;

    int   checks = 0;
    int   passed = 0;
    ent_t q[$];
    logic        exp_exc;
    logic [31:0] exp_bad;

    always #5 clk = ~clk;

    store_aligner dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .exc_valid    (exc_valid),
        .exc_badvaddr (exc_badvaddr)
    );

    function automatic ent_t model_pack(input logic [31:0] a, input logic [31:0] d, input int s);
        ent_t e;
        e.addr = a - (a % 4);
        if (s == 0) begin
            e.wdata = (d & 32'hFF) * 32'h01010101;
            e.be    = 4'(1 << (a % 4));
        end else if (s == 1) begin
            e.wdata = (d & 32'hFFFF) * 32'h00010001;
            e.be    = ((a % 4) >= 2) ? 4'hC : 4'h3;
        end else begin
            e.wdata = d;
            e.be    = 4'hF;
        end
        return e;
    endfunction

    function automatic logic model_drops(input logic [31:0] a, input int s);
        logic bad;
        bad = (s == 3);
`ifdef STORE_ALIGNER_MISALIGN_EXC_EN
        if (s == 1 && (a % 2) != 0) bad = 1'b1;
        if (s == 2 && (a % 4) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input int s, input logic mr);
        logic acc, pop;
        req_valid = v; req_addr = a; req_data = d; req_size = 2'(s); mem_ready = mr;
        acc = v && (q.size() < 2);
        pop = (q.size() != 0) && mr;
        exp_exc = acc && model_drops(a, s);
        if (exp_exc) exp_bad = a;
        if (pop) void'(q.pop_front());
        if (acc && !model_drops(a, s)) q.push_back(model_pack(a, d, s));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic mr);
        drive(1'b0, 32'h0, 32'h0, 0, mr);
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
        q.delete(); exp_exc = 1'b0; exp_bad = '0;
        #12;
        @(negedge clk);
        checks++;
        if ({req_ready, mem_valid, mem_addr, mem_wdata, mem_be, exc_valid, exc_badvaddr} !== '0)
            $display("FAIL reset_state: got rdy=%b vld=%b addr=%h wd=%h be=%b exc=%b bad=%h, want all zero",
                     req_ready, mem_valid, mem_addr, mem_wdata, mem_be, exc_valid, exc_badvaddr);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_byte;
        drive(1'b1, 32'h1003, 32'hAABBCCDD, 0, 1'b1);
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h1000, 32'hDDDDDDDD, 4'b1000})
            $display("FAIL byte_store: got vld=%b addr=%h wd=%h be=%b want 1 00001000 dddddddd 1000",
                     mem_valid, mem_addr, mem_wdata, mem_be);
        else passed++;
        idle(1'b1);
        checks++;
        if (mem_valid !== 1'b0) $display("FAIL byte_drain: got vld=%b want 0", mem_valid);
        else passed++;
    endtask

    task automatic test_backpressure;
        drive(1'b1, 32'h2002, 32'h12345678, 1, 1'b0);
        drive(1'b1, 32'h2004, 32'hCAFEBABE, 2, 1'b0);
        checks++;
        if (req_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", req_ready);
        else passed++;
        mem_ready = 1'b1; req_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", req_ready);
        else passed++;
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== {32'h2000, 32'h56785678, 4'b1100})
            $display("FAIL half_head: got addr=%h wd=%h be=%b want 00002000 56785678 1100",
                     mem_addr, mem_wdata, mem_be);
        else passed++;
        drive(1'b1, 32'h2008, 32'h0BADF00D, 2, 1'b1);
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h2004, 32'hCAFEBABE, 4'b1111})
            $display("FAIL word_head: got vld=%b addr=%h wd=%h be=%b want 1 00002004 cafebabe 1111",
                     mem_valid, mem_addr, mem_wdata, mem_be);
        else passed++;
        idle(1'b1);
        checks++;
        if (mem_valid !== 1'b0) $display("FAIL no_bypass_drain: got vld=%b want 0", mem_valid);
        else passed++;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h5000, 32'h01020304, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h5004 + 32'(i * 4), $urandom, $urandom_range(0, 1), 1'b1);
            checks++;
            if (mem_valid !== 1'b1 || req_ready !== 1'b1 || q.size() != 1 ||
                {mem_addr, mem_wdata, mem_be} !== q[0])
                $display("FAIL push_pop_%0d: got vld=%b rdy=%b %h/%h/%b want 1 1 %h/%h/%b",
                         i, mem_valid, req_ready, mem_addr, mem_wdata, mem_be,
                         q[0].addr, q[0].wdata, q[0].be);
            else passed++;
        end
        idle(1'b1);
    endtask

    task automatic test_reserved;
        drive(1'b1, 32'h3000, 32'hFFFFFFFF, 3, 1'b1);
        checks++;
        if ({mem_valid, exc_valid, exc_badvaddr} !== {1'b0, 1'b1, 32'h3000})
            $display("FAIL reserved_exc: got vld=%b exc=%b bad=%h want 0 1 00003000",
                     mem_valid, exc_valid, exc_badvaddr);
        else passed++;
        idle(1'b1);
        checks++;
        if ({mem_valid, exc_valid, exc_badvaddr} !== {1'b0, 1'b0, 32'h3000})
            $display("FAIL reserved_pulse_end: got vld=%b exc=%b bad=%h want 0 0 00003000",
                     mem_valid, exc_valid, exc_badvaddr);
        else passed++;
    endtask

    task automatic test_misalign;
        drive(1'b1, 32'h4002, 32'h11223344, 2, 1'b1);
        checks++;
`ifdef STORE_ALIGNER_MISALIGN_EXC_EN
        if ({mem_valid, exc_valid, exc_badvaddr} !== {1'b0, 1'b1, 32'h4002})
            $display("FAIL misalign_word: got vld=%b exc=%b bad=%h want 0 1 00004002",
                     mem_valid, exc_valid, exc_badvaddr);
        else passed++;
`else
        if ({mem_valid, mem_addr, mem_wdata, mem_be, exc_valid} !== {1'b1, 32'h4000, 32'h11223344, 4'hF, 1'b0})
            $display("FAIL misalign_word: got vld=%b addr=%h wd=%h be=%b exc=%b want 1 00004000 11223344 1111 0",
                     mem_valid, mem_addr, mem_wdata, mem_be, exc_valid);
        else passed++;
`endif
        idle(1'b1);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            a = 32'h6000 + 32'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 3) != 0), a, $urandom, $urandom_range(0, 3),
                  1'($urandom_range(0, 2) != 0));
            checks++;
            if (mem_valid !== (q.size() != 0) || req_ready !== (q.size() < 2) ||
                exc_valid !== exp_exc || exc_badvaddr !== exp_bad ||
                (q.size() != 0 && {mem_addr, mem_wdata, mem_be} !== q[0]))
                $display("FAIL random_%0d: got vld=%b rdy=%b %h/%h/%b exc=%b bad=%h want occ=%0d exc=%b bad=%h",
                         i, mem_valid, req_ready, mem_addr, mem_wdata, mem_be, exc_valid, exc_badvaddr,
                         q.size(), exp_exc, exp_bad);
            else passed++;
        end
        while (q.size() != 0) idle(1'b1);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 32'h7000, 32'h11111111, 2, 1'b0);
        drive(1'b1, 32'h7004, 32'h22222222, 2, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_valid, req_ready, mem_be, exc_badvaddr} !== '0)
            $display("FAIL reset_mid_immediate: got vld=%b rdy=%b be=%b bad=%h want all zero",
                     mem_valid, req_ready, mem_be, exc_badvaddr);
        else passed++;
        q.delete(); exp_exc = 1'b0; exp_bad = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            checks++;
            if (mem_valid !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL reset_mid_stale_%0d: got vld=%b rdy=%b want 0 1", i, mem_valid, req_ready);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_byte;
        test_backpressure;
        test_back_to_back;
        test_reserved;
        test_misalign;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
